mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between an instruction-fetch requester (fe) and a
//   load/store requester (ls). One transaction is in flight at a time. ls has
//   priority, but after STARVE_MAX consecutive ls grants made while fe was
//   waiting, fe is served next.
//
//   Ports
//     clk, reset               clock, synchronous active-high reset
//     fe_req/fe_addr           fetch read request (held until fe_gnt)
//     fe_gnt/fe_rvalid/fe_rdata  fetch grant pulse and read response
//     fe_flush                 drop the response of the fetch in flight
//     ls_req/ls_we/ls_addr/ls_wdata/ls_size  load/store request
//     ls_gnt/ls_rvalid/ls_rdata  load/store grant pulse and read response
//     mem_en/mem_we/mem_addr/mem_wdata/mem_size  shared memory command
//     mem_rdata                read data, valid LATENCY cycles after mem_en
//
//   state | meaning
//   IDLE  | sample requests, pick a winner, register its command
//   BUSY  | one cycle: command on the memory port, winner's gnt pulses
//   WAIT  | LATENCY cycles of read latency; owner's rvalid in the last one

module mem_port_arbiter #(
    parameter int WIDTH      = 32,
    parameter int LATENCY    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fe_req,
    input  logic [WIDTH-1:0] fe_addr,
    output logic             fe_gnt,
    output logic             fe_rvalid,
    output logic [WIDTH-1:0] fe_rdata,
    input  logic             fe_flush,
    input  logic             ls_req,
    input  logic             ls_we,
    input  logic [WIDTH-1:0] ls_addr,
    input  logic [WIDTH-1:0] ls_wdata,
    input  logic [2:0]       ls_size,
    output logic             ls_gnt,
    output logic             ls_rvalid,
    output logic [WIDTH-1:0] ls_rdata,
    output logic             mem_en,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [2:0]       mem_size,
    input  logic [WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        WAIT = 2'd2
    } state_t;

    // The wait timer counts down to zero; zero marks the last WAIT cycle.
    localparam logic [2:0] WAIT_LOAD  = 3'(LATENCY - 1);
    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);
    localparam logic [2:0] FE_SIZE    = 3'b010;

    state_t     state;
    logic [2:0] starve_cnt;
    logic [2:0] wait_cnt;
    logic       cmd_fe;
    logic       fe_flushed;
    logic       fe_wins;
    logic       last_wait;

    assign fe_wins   = fe_req && (!ls_req || (starve_cnt == STARVE_LIM));
    assign last_wait = (state == WAIT) && (wait_cnt == 3'd0);

    // A flush in the final WAIT cycle must hide that same cycle's response,
    // so the live fe_flush is gated in alongside the sticky flag.
    assign fe_rvalid = last_wait && cmd_fe && !fe_flushed && !fe_flush;
    assign ls_rvalid = last_wait && !cmd_fe;
    assign fe_rdata  = fe_rvalid ? mem_rdata : '0;
    assign ls_rdata  = ls_rvalid ? mem_rdata : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            starve_cnt <= 3'd0;
            wait_cnt   <= 3'd0;
            cmd_fe     <= 1'b0;
            fe_flushed <= 1'b0;
            fe_gnt     <= 1'b0;
            ls_gnt     <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_size   <= 3'd0;
        end else begin
            fe_gnt <= 1'b0;
            ls_gnt <= 1'b0;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (!fe_req) begin
                        starve_cnt <= 3'd0;
                    end
                    if (fe_req || ls_req) begin
                        state      <= BUSY;
                        mem_en     <= 1'b1;
                        fe_flushed <= 1'b0;
                        if (fe_wins) begin
                            cmd_fe     <= 1'b1;
                            fe_gnt     <= 1'b1;
                            mem_we     <= 1'b0;
                            mem_addr   <= fe_addr;
                            mem_size   <= FE_SIZE;
                            starve_cnt <= 3'd0;
                        end else begin
                            cmd_fe    <= 1'b0;
                            ls_gnt    <= 1'b1;
                            mem_we    <= ls_we;
                            mem_addr  <= ls_addr;
                            mem_wdata <= ls_wdata;
                            mem_size  <= ls_size;
                            if (fe_req && (starve_cnt != 3'd7)) begin
                                starve_cnt <= starve_cnt + 3'd1;
                            end
                        end
                    end
                end
                BUSY: begin
                    if (cmd_fe && fe_flush) begin
                        fe_flushed <= 1'b1;
                    end
                    // mem_we still holds this transaction's write flag here.
                    if (mem_we) begin
                        state <= IDLE;
                    end else begin
                        state    <= WAIT;
                        wait_cnt <= WAIT_LOAD;
                    end
                end
                WAIT: begin
                    if (cmd_fe && fe_flush) begin
                        fe_flushed <= 1'b1;
                    end
                    if (wait_cnt == 3'd0) begin
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
